bk_adder_pipe: RTL and testbench

//  Parametrised 3-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.

---
 rtl/bk_adder_pkg.sv | 22 ++
 rtl/bk_prefix_tree.sv | 30 +++
 rtl/bk_adder_pipe.sv | 136 +++++++++++++
 tb/tb_bk_adder_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_adder_pkg.sv
// bk_adder_pkg: shared types, latency constant and prefix helpers for bk_adder_pipe
//   BKA_LATENCY  accept-to-result latency in cycles with no backpressure
//   bka_pg_t     propagate/generate pair carried through the prefix tree
//   bka_mode_e   operation mode, encoded as {sub, signed}
//   bka_levels   ceil(log2(w)), the number of up-sweep levels for w positions
//   bka_op       prefix combine: high group absorbs the lower group below it
package bk_adder_pkg;
  localparam int BKA_LATENCY = 3;
  typedef struct packed {
    logic p;
    logic g;
  } bka_pg_t;
  typedef enum logic [1:0] {ADD_U, ADD_S, SUB_U, SUB_S} bka_mode_e;
  function automatic int bka_levels(input int w);
    int n = 0;
    while ((1 << n) < w) n++;
    return n;
  endfunction
  function automatic bka_pg_t bka_op(input bka_pg_t h, input bka_pg_t l);
    return '{p: h.p & l.p, g: h.g | (h.p & l.g)};
  endfunction
endpackage

// File: rtl/bk_prefix_tree.sv
// bk_prefix_tree: combinational Brent-Kung prefix network split into up-sweep and down-sweep halves
//   up_i/up_o  N bitwise p/g pairs in, odd-aligned group p/g pairs out
//   dn_i/dn_o  registered up-sweep result in, full prefix p/g at every position out
// The two halves share no signals so the caller can place a register between them.
// Positions whose partner index falls outside 0..N-1 simply pass through.
module bk_prefix_tree
  import bk_adder_pkg::*;
#(
  parameter int N = 21
) (
  input  bka_pg_t [N-1:0] up_i,
  output bka_pg_t [N-1:0] up_o,
  input  bka_pg_t [N-1:0] dn_i,
  output bka_pg_t [N-1:0] dn_o
);
  localparam int L = bka_levels(N);
  always_comb begin
    up_o = up_i;
    for (int l = 1; l <= L; l++)
      for (int j = 0; j < N; j++)
        if ((j + 1) % (1 << l) == 0) up_o[j] = bka_op(up_o[j], up_o[j - (1 << (l - 1))]);
  end
  always_comb begin
    dn_o = dn_i;
    for (int l = L - 1; l >= 1; l--)
      for (int j = 0; j < N; j++)
        if ((j + 1) % (1 << l) == 0 && j + (1 << (l - 1)) < N)
          dn_o[j + (1 << (l - 1))] = bka_op(dn_o[j + (1 << (l - 1))], dn_o[j]);
  end
endmodule

// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: 3-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operation handshake; in_a, in_b, in_cin, in_signed, in_sub, in_tag
//   out_valid/out_ready result handshake; out_sum (WIDTH+1 bits, exact), out_tag
// Optional BK_ADDER_PIPE_SKID_EN: 2-entry skid buffer ahead of stage 1 with a registered in_ready.
// The carry-in rides the prefix tree as an extra position 0 (g=c0, p=0), so the
// prefix at position i is the carry into sum bit i.
module bk_adder_pipe
  import bk_adder_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_signed,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = WIDTH + 1;
  localparam int M = N + 1;
  localparam int IW = 2 * WIDTH + TAG_W + 3;
  logic ld1, ld2, ld3, s_valid, s_cin, s_sgn, s_sub, sub_m, sgn_m, c0;
  logic [IW-1:0] in_bus, s_bus;
  logic [WIDTH-1:0] s_a, s_b;
  logic [TAG_W-1:0] s_tag, tag1_q, tag2_q, tag3_q;
  logic [N-1:0] a_ext, b_ext, p1_q, g1_q, p2_q, sum_d, sum3_q;
  logic v1_q, v2_q, v3_q, c1_q, unused_dn;
  bka_mode_e mode;
  bka_pg_t [M-1:0] up_in, up_out, up2_q, dn_out;
  assign in_bus = {in_a, in_b, in_cin, in_signed, in_sub, in_tag};
  assign {s_a, s_b, s_cin, s_sgn, s_sub, s_tag} = s_bus;
`ifdef BK_ADDER_PIPE_SKID_EN
  logic [IW-1:0] skid_q [2];
  logic [1:0] cnt_q, cnt_d;
  logic rd_q, wr_q, rdy_q, push, pop;
  // An empty skid is bypassed so latency stays at 3; queued entries always go first.
  assign in_ready = rdy_q;
  assign s_valid = cnt_q != 2'd0 || (in_valid && rdy_q);
  assign s_bus = cnt_q != 2'd0 ? skid_q[rd_q] : in_bus;
  assign pop = cnt_q != 2'd0 && ld1;
  assign push = in_valid && rdy_q && !(cnt_q == 2'd0 && ld1);
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rd_q <= rd_q ^ pop;
      wr_q <= wr_q ^ push;
      rdy_q <= cnt_d < 2'd2;
    end
  always_ff @(posedge clk)
    if (push) skid_q[wr_q] <= in_bus;
`else
  assign s_valid = in_valid;
  assign s_bus = in_bus;
  assign in_ready = !v1_q || ld2;
`endif
  // Bubble-collapsing: a stage loads whenever it is empty or its content moves on.
  assign ld3 = v2_q && (!v3_q || out_ready);
  assign ld2 = v1_q && (!v2_q || ld3);
  assign ld1 = s_valid && (!v1_q || ld2);
  assign mode = bka_mode_e'({s_sub, s_sgn});
  assign sub_m = mode == SUB_U || mode == SUB_S;
  assign sgn_m = mode == ADD_S || mode == SUB_S;
  assign a_ext = {sgn_m & s_a[WIDTH-1], s_a};
  assign b_ext = {sgn_m & s_b[WIDTH-1], s_b} ^ {N{sub_m}};
  assign c0 = s_cin ^ sub_m;
  always_comb begin
    up_in = '0;
    up_in[0] = '{p: 1'b0, g: c1_q};
    for (int i = 0; i < N; i++) up_in[i+1] = '{p: p1_q[i], g: g1_q[i]};
  end
  bk_prefix_tree #(.N(M)) u_tree (
    .up_i(up_in),
    .up_o(up_out),
    .dn_i(up2_q),
    .dn_o(dn_out)
  );
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) sum_d[i] = p2_q[i] ^ dn_out[i].g;
  end
  // Carry-out past bit WIDTH and the group propagates are not needed for the exact result.
  assign unused_dn = ^dn_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p1_q <= '0;
      g1_q <= '0;
      c1_q <= 1'b0;
      tag1_q <= '0;
      up2_q <= '0;
      p2_q <= '0;
      tag2_q <= '0;
      sum3_q <= '0;
      tag3_q <= '0;
    end else begin
      v1_q <= ld1 || (v1_q && !ld2);
      v2_q <= ld2 || (v2_q && !ld3);
      v3_q <= ld3 || (v3_q && !out_ready);
      if (ld1) begin
        p1_q <= a_ext ^ b_ext;
        g1_q <= a_ext & b_ext;
        c1_q <= c0;
        tag1_q <= s_tag;
      end
      if (ld2) begin
        up2_q <= up_out;
        p2_q <= p1_q;
        tag2_q <= tag1_q;
      end
      if (ld3) begin
        sum3_q <= sum_d;
        tag3_q <= tag2_q;
      end
    end
  assign out_valid = v3_q;
  assign out_sum = sum3_q;
  assign out_tag = tag3_q;
endmodule

// File: tb/tb_bk_adder_pipe.sv
// tb_bk_adder_pipe: scoreboard bench for bk_adder_pipe at WIDTH 19, 8 and 32 sharing one handshake stream
module tb_bk_adder_pipe;
  import bk_adder_pkg::*;
  typedef struct {
    logic [63:0] sum;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cin = 0, sgn = 0, sub = 0;
  logic [3:0] tag = 0, t19, t8, t32;
  logic [18:0] a19 = 0, b19 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic r19, r8, r32, v19, v8, v32;
  logic [19:0] s19;
  logic [8:0] s8;
  logic [32:0] s32;
  int total = 0, bad = 0, cyc = 0;
  bit lat_chk = 0;
  exp_t q19[$], q8[$], q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bk_adder_pipe #(.WIDTH(19), .TAG_W(4)) dut19 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r19), .in_a(a19), .in_b(b19),
    .in_cin(cin), .in_signed(sgn), .in_sub(sub), .in_tag(tag), .out_valid(v19),
    .out_ready(out_ready), .out_sum(s19), .out_tag(t19));
  bk_adder_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_cin(cin), .in_signed(sgn), .in_sub(sub), .in_tag(tag), .out_valid(v8),
    .out_ready(out_ready), .out_sum(s8), .out_tag(t8));
  bk_adder_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32), .in_a(a32), .in_b(b32),
    .in_cin(cin), .in_signed(sgn), .in_sub(sub), .in_tag(tag), .out_valid(v32),
    .out_ready(out_ready), .out_sum(s32), .out_tag(t32));

  // Golden model: extend per signedness, do the arithmetic on integers, keep w+1 bits.
  function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
    longint av = longint'(a), bv = longint'(b);
    logic [63:0] r;
    if (sgn && a[w-1]) av -= longint'(1) << w;
    if (sgn && b[w-1]) bv -= longint'(1) << w;
    r = sub ? av - bv - longint'(cin) : av + bv + longint'(cin);
    return r & ((64'd1 << (w + 1)) - 64'd1);
  endfunction

  function automatic logic [63:0] corner(input int k, input int w);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    case (k)
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'h5555_5555_5555_5555 & m;
      default: return 64'hAAAA_AAAA_AAAA_AAAA & m;
    endcase
  endfunction

  task automatic eq(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [3:0] gt, ref exp_t q[$]);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected result sum=%h tag=%h", nm, got, gt);
    end else begin
      e = q.pop_front();
      if (got !== e.sum || gt !== e.tag || (e.lat && cyc - e.cyc != BKA_LATENCY)) begin
        bad++;
        $display("FAIL %s got sum=%h tag=%h lat=%0d want sum=%h tag=%h lat=%0d",
                 nm, got, gt, cyc - e.cyc, e.sum, e.tag, BKA_LATENCY);
      end
    end
  endtask

  // Scoreboard input side: every handshake queues the model's answer for that width.
  always @(negedge clk)
    if (!rst && in_valid) begin
      if (r19) q19.push_back('{model(19, 64'(a19), 64'(b19)), tag, cyc, lat_chk});
      if (r8) q8.push_back('{model(8, 64'(a8), 64'(b8)), tag, cyc, lat_chk});
      if (r32) q32.push_back('{model(32, 64'(a32), 64'(b32)), tag, cyc, lat_chk});
    end

  // Monitor: pops and compares whenever a result is consumed.
  always @(negedge clk)
    if (!rst) begin
      if (v19 && out_ready) chk("w19", 64'(s19), t19, q19);
      if (v8 && out_ready) chk("w8", 64'(s8), t8, q8);
      if (v32 && out_ready) chk("w32", 64'(s32), t32, q32);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    int n = 0;
    in_valid = 1;
    #1;
    while (!r19 && n < 100) begin
      step();
      n++;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL send: in_ready stuck low");
    end
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q19.size() + q8.size() + q32.size() != 0 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (n == 50) begin
      bad++;
      $display("FAIL drain: %0d results missing", q19.size() + q8.size() + q32.size());
    end
  endtask

  task automatic rand_ops();
    a19 = 19'($urandom);
    b19 = 19'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a32 = $urandom;
    b32 = $urandom;
  endtask

  task automatic set_corner(input int i, input int j);
    a19 = 19'(corner(i, 19));
    b19 = 19'(corner(j, 19));
    a8 = 8'(corner(i, 8));
    b8 = 8'(corner(j, 8));
    a32 = 32'(corner(i, 32));
    b32 = 32'(corner(j, 32));
  endtask

  initial begin
    int n, c0;
    #2;
    eq("rst_valid", 64'(v19), 64'd0);
    eq("rst_sum", 64'(s19), 64'd0);
    eq("rst_tag", 64'(t19), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    // directed: unsigned max add with carry-in, latency checked
    lat_chk = 1;
    a19 = 19'h7FFFF;
    b19 = 19'h7FFFF;
    cin = 1;
    tag = 4'h5;
    send();
    drain();
    // directed: signed min result and unsigned borrow to -1
    sgn = 1;
    sub = 1;
    a19 = 19'h40000;
    b19 = 19'h3FFFF;
    cin = 1;
    tag = 4'h1;
    send();
    sgn = 0;
    a19 = 19'h0;
    b19 = 19'h1;
    cin = 0;
    tag = 4'h2;
    send();
    drain();
    // back-to-back random stream at full rate
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      {cin, sgn, sub} = 3'($urandom);
      tag = 4'($urandom);
      send();
    end
    eq("throughput", 64'(cyc - c0), 64'd16);
    drain();
    // fill with out_ready low, hold, then release with more traffic
    lat_chk = 0;
    out_ready = 0;
    in_valid = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      rand_ops();
      tag = 4'(i);
      #1;
      if (r19) n++;
      step();
    end
    in_valid = 0;
    eq("fill_accepts", 64'(n), 64'd3);
    eq("fill_ready", 64'(r19), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      eq("hold_valid", 64'(v19), 64'd1);
      eq("hold_sum", 64'(s19), q19[0].sum);
      eq("hold_tag", 64'(t19), 64'(q19[0].tag));
    end
    out_ready = 1;
    #1;
    eq("release_ready", 64'(r19), 64'd1);
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      tag = 4'(8 + i);
      send();
    end
    drain();
    // reset with two operations in flight
    rand_ops();
    tag = 4'h3;
    send();
    tag = 4'h4;
    send();
    rst = 1;
    #1;
    eq("midrst_valid", 64'(v19), 64'd0);
    eq("midrst_sum", 64'(s19), 64'd0);
    eq("midrst_tag", 64'(t19), 64'd0);
    q19.delete();
    q8.delete();
    q32.delete();
    step();
    rst = 0;
    rand_ops();
    tag = 4'hA;
    send();
    drain();
    // corner sweep over every mode and carry-in at all three widths
    lat_chk = 1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int m = 0; m < 8; m++) begin
          set_corner(i, j);
          {sub, sgn, cin} = 3'(m);
          tag = 4'(m + i);
          send();
        end
    drain();
    // random traffic with random backpressure
    lat_chk = 0;
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      {cin, sgn, sub} = 3'($urandom);
      tag = 4'($urandom);
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    in_valid = 0;
    out_ready = 1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
